regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
Shares the single write port of the 8x16 register file between two writeback requesters: A (ALU result) and B (load/memory result). Each requester uses a req/grant handshake. Arbitration is round-robin. The winner's address and data are registered into an output stage that drives RD/RegWrite/WriteData of the register file. A saturating conflict counter is provided for performance observation.

Parameters:
DATA_WIDTH, 16, width of write data (matches register width).
ADDR_WIDTH, 3, register address width (8 registers).
CNT_WIDTH, 8, width of ConflictCount.
ZERO_REG_PROTECT, 0, if 1 then writes addressed to register 0 are granted but discarded (RegWrite stays 0).

Ports:
Clock  in  1  single clock; all state updates on rising edge.
Reset_n  in  1  asynchronous, active-low reset.
ReqA  in  1  requester A has a write pending; held until granted.
AddrA  in  ADDR_WIDTH  destination register of A.
DataA  in  DATA_WIDTH  write data of A.
GrantA  out  1  combinational; A's request is accepted at the next rising edge.
ReqB  in  1  as ReqA, for requester B.
AddrB  in  ADDR_WIDTH  destination register of B.
DataB  in  DATA_WIDTH  write data of B.
GrantB  out  1  as GrantA, for requester B.
Hold  in  1  when 1, no grants are issued (pipeline stall/flush).
RD  out  ADDR_WIDTH  registered write address to the register file.
RegWrite  out  1  registered write enable to the register file.
WriteData  out  DATA_WIDTH  registered write data to the register file.
ConflictCount  out  CNT_WIDTH  saturating count of cycles with ReqA&ReqB&!Hold.

Behaviour:
- Reset (Reset_n=0, takes effect immediately, independent of Clock): RegWrite=0, RD=0, WriteData=0, ConflictCount=0, LastGrant=B (so A wins the first conflict). GrantA and GrantB are forced to 0 while Reset_n=0.
- Grant logic is combinational from ReqA, ReqB, Hold and LastGrant only. It never depends on Addr or Data.
  - Hold=1: GrantA=GrantB=0.
  - Only ReqA: GrantA=1.
  - Only ReqB: GrantB=1.
  - Both requesting: grant the requester that is not LastGrant.
  - Neither requesting: no grant.
  - GrantA and GrantB are never both 1.
- Transfer: a transfer occurs at a rising edge where Req&Grant=1 for a requester. The requester must hold Req/Addr/Data stable until that edge and may drop Req or present a new request in the following cycle.
- On a transfer edge:
  - LastGrant is set to the granted requester.
  - RD and WriteData are set to the granted Addr and Data.
  - RegWrite is set to 1, except when ZERO_REG_PROTECT=1 and Addr=0, in which case RegWrite is set to 0.
- On an edge without a transfer: RegWrite is set to 0. RD and WriteData hold their values.
- Latency: a request granted in cycle k drives RegWrite=1 during cycle k+1. The register file commits the write at the end of cycle k+1. Throughput is one write per cycle.
- No starvation: under continuous ReqA&ReqB, grants alternate A,B,A,B.
- LastGrant changes only on a transfer edge. Idle cycles and Hold cycles do not alter priority.
- Same destination from both requesters in the same cycle: no merging. The two writes are serialised in round-robin order, and the later transfer determines the final register value.
- ConflictCount increments by 1 on every edge where ReqA&ReqB&!Hold. It saturates at 2^CNT_WIDTH-1 and never wraps. It is cleared only by reset.
- Reset mid-operation: a write captured in the output stage but not yet committed is lost (RegWrite is cleared asynchronously). Requesters that were not granted simply keep Req asserted after reset.
- Hold asserted in the same cycle as a request: no grant and no transfer. If the output stage held a write, that write still completes (RegWrite is 1 for exactly one cycle), and RegWrite is 0 on the following edge.

Test Plan:
- Reset then idle: Reset_n low for 2 cycles, then high with no requests. Expect RegWrite=0, RD=0, WriteData=0, ConflictCount=0, GrantA=GrantB=0 throughout.
- Single writer: ReqA=1, AddrA=3, DataA=16'h1234 for one cycle. Expect GrantA=1 that cycle, then the next cycle RegWrite=1, RD=3, WriteData=16'h1234, then RegWrite=0.
- Conflict round-robin: ReqA and ReqB held for 4 cycles (AddrA=1, DataA=16'hAAAA; AddrB=2, DataB=16'hBBBB). Expect grants in order A,B,A,B and outputs alternating RD=1/2 with matching data. ConflictCount=4.
- Hold: ReqA=1 with Hold=1 for 3 cycles, then Hold=0. Expect no grant and RegWrite=0 during Hold, GrantA in the first cycle after release, and RegWrite=1 one cycle later.
- Zero protect (ZERO_REG_PROTECT=1): ReqB=1, AddrB=0, DataB=16'hFFFF. Expect GrantB=1, RegWrite=0 the next cycle, and LastGrant=B (a subsequent conflict grants A first).
- Saturation and async reset: hold the conflict for 300 cycles with CNT_WIDTH=8. Expect ConflictCount=255. Then pulse Reset_n low mid-cycle. Expect ConflictCount=0 and RegWrite=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin arbiter sharing the register-file write port between two writeback requesters
module regfile_write_arbiter #(
  parameter int DATA_WIDTH       = 16,
  parameter int ADDR_WIDTH       = 3,
  parameter int CNT_WIDTH        = 8,
  parameter bit ZERO_REG_PROTECT = 1'b0
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  input  logic                  ReqA,
  input  logic [ADDR_WIDTH-1:0] AddrA,
  input  logic [DATA_WIDTH-1:0] DataA,
  output logic                  GrantA,
  input  logic                  ReqB,
  input  logic [ADDR_WIDTH-1:0] AddrB,
  input  logic [DATA_WIDTH-1:0] DataB,
  output logic                  GrantB,
  input  logic                  Hold,
  output logic [ADDR_WIDTH-1:0] RD,
  output logic                  RegWrite,
  output logic [DATA_WIDTH-1:0] WriteData,
  output logic [CNT_WIDTH-1:0]  ConflictCount
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  typedef enum logic {LAST_A = 1'b0, LAST_B = 1'b1} last_t;

  last_t                 last_grant;
  logic                  conflict;
  logic                  transfer;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_data;
  logic                  win_write;

  // Grants look only at requests, Hold and priority; Reset_n gating keeps them quiet during reset.
  always_comb begin
    GrantA = 1'b0;
    GrantB = 1'b0;
    if (Reset_n && !Hold) begin
      if (ReqA && ReqB) begin
        GrantA = (last_grant == LAST_B);
        GrantB = (last_grant == LAST_A);
      end else begin
        GrantA = ReqA;
        GrantB = ReqB;
      end
    end
  end

  assign conflict = ReqA && ReqB && !Hold;
  assign transfer = (ReqA && GrantA) || (ReqB && GrantB);

  always_comb begin
    win_addr = AddrA;
    win_data = DataA;
    if (GrantB) begin
      win_addr = AddrB;
      win_data = DataB;
    end
    // Writes to register 0 are still accepted so the requester is released, but never committed.
    win_write = !(ZERO_REG_PROTECT && (win_addr == '0));
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      last_grant <= LAST_B;
      RD         <= '0;
      WriteData  <= '0;
      RegWrite   <= 1'b0;
    end else if (transfer) begin
      last_grant <= GrantB ? LAST_B : LAST_A;
      RD         <= win_addr;
      WriteData  <= win_data;
      RegWrite   <= win_write;
    end else begin
      RegWrite   <= 1'b0;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      ConflictCount <= '0;
    end else if (conflict && (ConflictCount != CNT_MAX)) begin
      ConflictCount <= ConflictCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_a, req_b, hold;
  logic [2:0]  addr_a, addr_b;
  logic [15:0] data_a, data_b;
  logic        grant_a, grant_b;
  logic [2:0]  rd;
  logic        reg_write;
  logic [15:0] write_data;
  logic [7:0]  conflict_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter #(
    .DATA_WIDTH(16), .ADDR_WIDTH(3), .CNT_WIDTH(8), .ZERO_REG_PROTECT(1'b1)
  ) dut (
    .Clock(clk), .Reset_n(rst_n),
    .ReqA(req_a), .AddrA(addr_a), .DataA(data_a), .GrantA(grant_a),
    .ReqB(req_b), .AddrB(addr_b), .DataB(data_b), .GrantB(grant_b),
    .Hold(hold), .RD(rd), .RegWrite(reg_write), .WriteData(write_data),
    .ConflictCount(conflict_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic we, input logic [2:0] a, input logic [15:0] d);
    chk({tag, "_we"}, 32'(reg_write), 32'(we));
    chk({tag, "_rd"}, 32'(rd), 32'(a));
    chk({tag, "_wd"}, 32'(write_data), 32'(d));
  endtask

  task automatic chk_grant(input string tag, input logic ga, input logic gb);
    chk({tag, "_ga"}, 32'(grant_a), 32'(ga));
    chk({tag, "_gb"}, 32'(grant_b), 32'(gb));
  endtask

  initial begin
    rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; hold = 1'b0;
    addr_a = '0; addr_b = '0; data_a = '0; data_b = '0;

    // reset then idle
    #1;
    chk_out("reset", 1'b0, 3'd0, 16'h0);
    chk("reset_cnt", 32'(conflict_count), 32'd0);
    chk_grant("reset", 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk_out("idle", 1'b0, 3'd0, 16'h0);
      chk_grant("idle", 1'b0, 1'b0);
      chk("idle_cnt", 32'(conflict_count), 32'd0);
    end

    // single writer
    req_a = 1'b1; addr_a = 3'd3; data_a = 16'h1234;
    #1 chk_grant("single", 1'b1, 1'b0);
    @(negedge clk);
    req_a = 1'b0;
    chk_out("single_wr", 1'b1, 3'd3, 16'h1234);
    @(negedge clk);
    chk_out("single_after", 1'b0, 3'd3, 16'h1234);

    // async reset pulse restores LastGrant=B before the conflict test
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    @(negedge clk);

    // conflict round-robin
    req_a = 1'b1; addr_a = 3'd1; data_a = 16'hAAAA;
    req_b = 1'b1; addr_b = 3'd2; data_b = 16'hBBBB;
    for (int i = 0; i < 4; i++) begin
      #1 chk_grant($sformatf("rr%0d", i), (i % 2) == 0, (i % 2) == 1);
      @(negedge clk);
      if ((i % 2) == 0) chk_out($sformatf("rr%0d", i), 1'b1, 3'd1, 16'hAAAA);
      else              chk_out($sformatf("rr%0d", i), 1'b1, 3'd2, 16'hBBBB);
    end
    req_a = 1'b0; req_b = 1'b0;
    chk("rr_cnt", 32'(conflict_count), 32'd4);
    @(negedge clk);
    chk("rr_idle_we", 32'(reg_write), 32'd0);
    chk("rr_idle_cnt", 32'(conflict_count), 32'd4);

    // hold blocks grants
    req_a = 1'b1; addr_a = 3'd5; data_a = 16'h5555; hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk_grant($sformatf("hold%0d", i), 1'b0, 1'b0);
      @(negedge clk);
      chk($sformatf("hold%0d_we", i), 32'(reg_write), 32'd0);
    end
    hold = 1'b0;
    #1 chk_grant("hold_rel", 1'b1, 1'b0);
    @(negedge clk);
    req_a = 1'b0;
    chk_out("hold_rel_wr", 1'b1, 3'd5, 16'h5555);

    // hold arriving while a write sits in the output stage
    @(negedge clk);
    req_a = 1'b1; addr_a = 3'd6; data_a = 16'h6666;
    @(negedge clk);
    req_a = 1'b0; req_b = 1'b1; addr_b = 3'd4; data_b = 16'h4444; hold = 1'b1;
    chk_out("hold_pend", 1'b1, 3'd6, 16'h6666);
    #1 chk_grant("hold_pend", 1'b0, 1'b0);
    @(negedge clk);
    chk_out("hold_pend_done", 1'b0, 3'd6, 16'h6666);
    req_b = 1'b0; hold = 1'b0;

    // zero-register protect: granted, discarded, priority moves to B
    req_b = 1'b1; addr_b = 3'd0; data_b = 16'hFFFF;
    #1 chk_grant("zero", 1'b0, 1'b1);
    @(negedge clk);
    chk_out("zero", 1'b0, 3'd0, 16'hFFFF);
    req_a = 1'b1; addr_a = 3'd1; data_a = 16'hAAAA;
    addr_b = 3'd2; data_b = 16'hBBBB;
    #1 chk_grant("zero_next", 1'b1, 1'b0);

    // saturation then asynchronous reset mid-cycle
    repeat (300) @(negedge clk);
    chk("sat_cnt", 32'(conflict_count), 32'd255);
    chk("sat_we", 32'(reg_write), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 3'd0, 16'h0);
    chk("async_rst_cnt", 32'(conflict_count), 32'd0);
    chk_grant("async_rst", 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk_grant("post_rst", 1'b1, 1'b0);
    @(negedge clk);
    chk_out("post_rst", 1'b1, 3'd1, 16'hAAAA);
    chk("post_rst_cnt", 32'(conflict_count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
